nn_mac_sequencer: RTL

- Sequences reads of the on-chip weight SRAM (4096x32) and the two pixel SRAMs (1024x16 each) to compute one dot product per output neuron.
- Each weight word packs two signed 16-bit weights: [31:16] pairs with pixel SRAM 1, [15:0] pairs with pixel SRAM 2.
- Arbitrates SRAM address ownership between itself and the Avalon load path, which fills the SRAMs.
- Streams per-neuron accumulated results to the output/softmax stage over a valid/ready handshake.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/nn_mac2.sv | 43 ++++
 rtl/nn_mac_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and widths for the MAC sequencer.
//   state_t  - sequencer states
//   WADDR_W  - weight SRAM address width (4096 words)
//   PADDR_W  - pixel SRAM address width (1024 words)
//   DATA_W   - signed pixel / half-weight width
package nn_pkg;

    localparam int WADDR_W = 12;
    localparam int PADDR_W = 10;
    localparam int DATA_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/nn_mac2.sv
// nn_mac2: registered dual-product signed multiply-accumulate.
//   clk, rst      - clock, synchronous active-high reset
//   i_clr         - clear accumulator (wins over i_en)
//   i_en          - accumulate i_w1*i_p1 + i_w2*i_p2 this cycle
//   i_w1,i_p1     - first signed operand pair
//   i_w2,i_p2     - second signed operand pair
//   o_acc         - signed accumulator, wraps modulo 2^ACC_W
module nn_mac2 import nn_pkg::*; #(
    parameter int ACC_W = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_w1,
    input  logic signed [DATA_W-1:0] i_p1,
    input  logic signed [DATA_W-1:0] i_w2,
    input  logic signed [DATA_W-1:0] i_p2,
    output logic signed [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] w_prod1;
    logic signed [PROD_W-1:0] w_prod2;
    logic signed [ACC_W-1:0]  r_acc;

    // 16x16 signed products are exact in 32 bits (even -2^15 * -2^15).
    assign w_prod1 = i_w1 * i_p1;
    assign w_prod2 = i_w2 * i_p2;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            // Signed size casts sign-extend each product to the accumulator width.
            r_acc <= r_acc + ACC_W'(w_prod1) + ACC_W'(w_prod2);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/nn_mac_sequencer.sv
// nn_mac_sequencer: walks weight/pixel SRAMs to produce one dot product per
// output neuron, and hands the SRAM buses to the load path while idle.
//   clk, rst                        - clock, synchronous active-high reset
//   start                           - pulse: begin a run (IDLE only, load_req low)
//   load_req / load_gnt             - load path bus request / grant (IDLE only)
//   busy                            - FETCH, DRAIN or EMIT
//   done                            - one-cycle pulse after the last result
//   weight_address, pixel_address1/2- registered SRAM read addresses
//   weight_value, pixel_value1/2    - SRAM read data, one cycle after address
//   result_valid/ready/index/data   - per-neuron result handshake
module nn_mac_sequencer import nn_pkg::*; #(
    parameter int NUM_PAIRS   = 392,
    parameter int NUM_NEURONS = 10,
    parameter int ACC_W       = 42
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               load_req,
    output logic               load_gnt,
    output logic               busy,
    output logic               done,
    output logic [11:0]        weight_address,
    input  logic [31:0]        weight_value,
    output logic [9:0]         pixel_address1,
    output logic [9:0]         pixel_address2,
    input  logic [15:0]        pixel_value1,
    input  logic [15:0]        pixel_value2,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [3:0]         result_index,
    output logic [ACC_W-1:0]   result_data
);

    state_t               r_state;
    state_t               w_next;
    logic [PADDR_W-1:0]   r_k;          // pair index, doubles as pixel address
    logic [WADDR_W-1:0]   r_waddr;      // n*NUM_PAIRS + k, kept incrementally
    logic [3:0]           r_n;
    logic                 r_stage_vld;  // SRAM data on the inputs is a live read
    logic                 w_clr;
    logic                 w_last_k;
    logic                 w_last_n;
    logic signed [ACC_W-1:0] w_acc;

    assign w_last_k = (r_k == PADDR_W'(NUM_PAIRS - 1));
    assign w_last_n = (r_n == 4'(NUM_NEURONS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                // load_req masks start so the load path keeps the buses.
                if (!load_req && start) begin
                    w_next = FETCH;
                    w_clr  = 1'b1;
                end
            end
            FETCH: begin
                if (w_last_k) w_next = DRAIN;
            end
            DRAIN: w_next = EMIT;
            EMIT: begin
                if (result_ready) begin
                    if (w_last_n) begin
                        w_next = DONE;
                    end else begin
                        w_next = FETCH;
                        w_clr  = 1'b1;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Addresses advance inside FETCH and freeze on the last pair, so they
    // hold through DRAIN/EMIT/DONE/IDLE. The next neuron's weight base is
    // simply the held last address plus one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= '0;
            r_waddr     <= '0;
            r_n         <= '0;
            r_stage_vld <= 1'b0;
        end else begin
            r_stage_vld <= (r_state == FETCH);
            if (r_state == IDLE && w_clr) begin
                r_k     <= '0;
                r_waddr <= '0;
                r_n     <= '0;
            end else if (r_state == EMIT && w_clr) begin
                r_k     <= '0;
                r_waddr <= r_waddr + 1'b1;
                r_n     <= r_n + 1'b1;
            end else if (r_state == FETCH && !w_last_k) begin
                r_k     <= r_k + 1'b1;
                r_waddr <= r_waddr + 1'b1;
            end
        end
    end

    // Upper weight half pairs with pixel SRAM 1, lower half with SRAM 2.
    nn_mac2 #(.ACC_W(ACC_W)) u_mac (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (r_stage_vld),
        .i_w1  (weight_value[31:16]),
        .i_p1  (pixel_value1),
        .i_w2  (weight_value[15:0]),
        .i_p2  (pixel_value2),
        .o_acc (w_acc)
    );

    assign load_gnt       = (r_state == IDLE) && load_req;
    assign busy           = (r_state == FETCH) || (r_state == DRAIN) || (r_state == EMIT);
    assign done           = (r_state == DONE);
    assign result_valid   = (r_state == EMIT);
    assign result_index   = r_n;
    // The accumulator is idle in EMIT, so it is the stable result.
    assign result_data    = w_acc;
    assign weight_address = r_waddr;
    assign pixel_address1 = r_k;
    assign pixel_address2 = r_k;

endmodule
